pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Parametrised successor to the fixed 4-stage branch lock/clear generator.
- Drives per-pipeline-register write enables (`lock`, 1 = write) and synchronous clears (`clear`, 1 = zero at next edge), plus the PC write enable.
- Arbitrates branch flush, load-use bubble and multi-cycle-op stall; adds a post-branch flush window and a stall counter.
- Sits beside the datapath; register i is the pipe register between stage i and stage i+1 (bit 0 = IF/ID).

Parameters:
- STAGES, 4: number of pipe registers; width of lock/clear.
- BRANCH_STAGE, 2: stage where branches and multi-cycle ops resolve (EX). Legal range 1..STAGES-1.
- FLUSH_EXTRA, 0: extra cycles after a taken branch that keep clear[0] asserted (fetch latency).
- MC_CNT_W, 4: width of mc_cycles and of the stall counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- branch_taken  in  1  taken branch resolved at BRANCH_STAGE this cycle
- load_use  in  1  load-use hazard detected in ID this cycle
- mc_start  in  1  multi-cycle op entered BRANCH_STAGE this cycle
- mc_cycles  in  MC_CNT_W  total EX occupancy of that op (sampled with mc_start)
- lock  out  STAGES  per-register write enable
- clear  out  STAGES  per-register synchronous clear
- pc_write  out  1  PC register write enable
- busy  out  1  high in MC_BUSY or FLUSH state

Behaviour:
- Reset: clock is the single clock; reset_n is asynchronous and active-low.
  - While reset_n = 0: lock = all 0, clear = all 1, pc_write = 0, busy = 0, state = RUN, counters = 0.
  - First edge after release operates normally.
- Output timing: outputs are combinational from state and inputs; state and counters are registered.
- States: RUN, MC_BUSY, FLUSH.
- RUN, idle: lock = all 1, clear = 0, pc_write = 1.
- RUN, priority is branch_taken > mc_start > load_use:
  - branch_taken: clear[BRANCH_STAGE-1:0] = 1, lock = all 1, pc_write = 1.
    - Next state is FLUSH with fcnt = FLUSH_EXTRA if FLUSH_EXTRA > 0, else RUN.
    - mc_start and load_use are ignored that cycle.
  - mc_start with M = mc_cycles:
    - M ≤ 1: no stall.
    - M ≥ 2, this cycle stalls: lock[BRANCH_STAGE-1:0] = 0, clear[BRANCH_STAGE] = 1, pc_write = 0.
    - M ≥ 3: next state MC_BUSY with scnt = M-2.
    - Total stall cycles = M-1. load_use is ignored.
  - load_use: lock[0] = 0, clear[1] = 1, pc_write = 0. Single cycle, no state change.
- MC_BUSY:
  - Same stall outputs as the mc_start stall cycle.
  - scnt decrements each cycle; at scnt == 1 the next state is RUN.
  - branch_taken, mc_start and load_use are ignored (upstream is frozen).
- FLUSH:
  - Outputs: clear[0] = 1, lock = all 1, pc_write = 1.
  - fcnt decrements; at fcnt == 1 the next state is RUN.
  - load_use and mc_start are ignored.
  - branch_taken reapplies the branch outputs and reloads fcnt = FLUSH_EXTRA.
- busy = (state != RUN).
- Width rules: scnt is MC_CNT_W bits; mc_cycles = 2^MC_CNT_W-1 is legal. Counters never wrap below 1 inside a state.
- Reset asserted mid-MC_BUSY or mid-FLUSH: abort immediately to the reset outputs; no residual stall after release.

Optional Feature:
- PIPE_PERF_CNT_EN defined: adds outputs stall_cycles[15:0] and flush_count[15:0].
  - stall_cycles increments on every cycle with pc_write = 0 outside reset.
  - flush_count increments on each accepted branch_taken.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and logic are absent.

Decomposition:
- Shared package pipeline_ctrl_pkg holds:
  - state encoding constants ST_RUN = 2'd0, ST_MC_BUSY = 2'd1, ST_FLUSH = 2'd2;
  - PERF_W = 16.
- One natural sub-module: pipe_stall_counter (loadable down-counter with load value, load enable, a done-at-1 flag and parametrised width), instantiated for both scnt and fcnt.

Test Plan (STAGES = 4, BRANCH_STAGE = 2):
- reset_n = 0 → lock = 4'b0000, clear = 4'b1111, pc_write = 0; release with inputs idle → lock = 4'b1111, clear = 4'b0000, pc_write = 1.
- branch_taken for 1 cycle, FLUSH_EXTRA = 0 → that cycle clear = 4'b0011, lock = 4'b1111, pc_write = 1, busy = 0; next cycle idle outputs.
- load_use for 1 cycle → lock = 4'b1110, clear = 4'b0010, pc_write = 0; next cycle idle; load_use with branch_taken in the same cycle → branch outputs only.
- mc_start, mc_cycles = 4 → 3 consecutive cycles lock = 4'b1100, clear = 4'b0100, pc_write = 0, busy = 1 for cycles 2-3; 4th cycle idle; mc_cycles = 1 → no stall.
- FLUSH_EXTRA = 2: branch_taken, then load_use held high → cycle 0 clear = 4'b0011, cycles 1-2 clear = 4'b0001 with pc_write = 1; load_use honoured from cycle 3.
- mc_start mc_cycles = 10, reset_n pulsed low in the 3rd stall cycle → reset outputs immediately; after release idle outputs, busy = 0; with PIPE_PERF_CNT_EN, stall_cycles = 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encoding
// and the width of the optional performance counters.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MC_BUSY = 2'd1,
        ST_FLUSH   = 2'd2
    } state_e;

    localparam int PERF_W = 16;

endpackage

// File: rtl/pipe_stall_counter.sv
// Loadable down-counter used for the multi-cycle stall and flush windows.
// done_o flags the last cycle of a window (count == 1). The count stops at
// zero, so an idle counter never wraps.
module pipe_stall_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: a load wins over a decrement; decrement stops at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: generates per-pipe-register write enables
// (lock), synchronous clears (clear) and the PC write enable from branch
// flush, load-use bubble and multi-cycle-op stall requests.
// Register i sits between stage i and stage i+1 (bit 0 = IF/ID).
// Optional build macro: PIPE_PERF_CNT_EN adds stall_cycles / flush_count.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int STAGES       = 4,
    parameter int BRANCH_STAGE = 2,
    parameter int FLUSH_EXTRA  = 0,
    parameter int MC_CNT_W     = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                branch_taken,
    input  logic                load_use,
    input  logic                mc_start,
    input  logic [MC_CNT_W-1:0] mc_cycles,
    output logic [STAGES-1:0]   lock,
    output logic [STAGES-1:0]   clear,
    output logic                pc_write,
    output logic                busy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]   stall_cycles,
    output logic [PERF_W-1:0]   flush_count
`endif
);

    // The flush counter only has to hold FLUSH_EXTRA.
    localparam int FCNT_W = (FLUSH_EXTRA > 1) ? $clog2(FLUSH_EXTRA + 1) : 1;

    localparam logic [MC_CNT_W-1:0] M_TWO   = MC_CNT_W'(2);
    localparam logic [MC_CNT_W-1:0] M_THREE = MC_CNT_W'(3);

    // Load-use bubble: hold IF/ID, insert a bubble into ID/EX.
    localparam logic [STAGES-1:0] LU_LOCK  = ~STAGES'(1);
    localparam logic [STAGES-1:0] LU_CLR   = STAGES'(2);
    // Post-branch flush window: keep squashing the fetched instruction.
    localparam logic [STAGES-1:0] FLUSH_CLR = STAGES'(1);

    state_e state_q;
    state_e state_d;

    logic [STAGES-1:0] br_clr_mask;
    logic [STAGES-1:0] stall_lock_mask;
    logic [STAGES-1:0] stall_clr_mask;

    logic scnt_load;
    logic scnt_dec;
    logic scnt_done;
    logic fcnt_load;
    logic fcnt_dec;
    logic fcnt_done;
    logic branch_acc;

    // Per-register masks: a branch squashes everything younger than the
    // resolving stage; a stall freezes those registers and bubbles the one
    // right after the resolving stage.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_mask
            assign br_clr_mask[gi]     = (gi < BRANCH_STAGE);
            assign stall_lock_mask[gi] = (gi >= BRANCH_STAGE);
            assign stall_clr_mask[gi]  = (gi == BRANCH_STAGE);
        end
    endgenerate

    // Stall counter: remaining MC_BUSY cycles after the first stall cycle.
    pipe_stall_counter #(
        .W (MC_CNT_W)
    ) u_scnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (scnt_load),
        .load_val_i (mc_cycles - M_TWO),
        .dec_i      (scnt_dec),
        .done_o     (scnt_done)
    );

    // Flush counter: remaining cycles of the post-branch flush window.
    pipe_stall_counter #(
        .W (FCNT_W)
    ) u_fcnt (
        .clock      (clock),
        .reset_n    (reset_n),
        .load_i     (fcnt_load),
        .load_val_i (FCNT_W'(FLUSH_EXTRA)),
        .dec_i      (fcnt_dec),
        .done_o     (fcnt_done)
    );

    // State register, aborted to RUN by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, counter controls and outputs; reset overrides the outputs.
    always_comb begin
        state_d    = state_q;
        lock       = '1;
        clear      = '0;
        pc_write   = 1'b1;
        scnt_load  = 1'b0;
        scnt_dec   = 1'b0;
        fcnt_load  = 1'b0;
        fcnt_dec   = 1'b0;
        branch_acc = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    clear      = br_clr_mask;
                    branch_acc = 1'b1;
                    if (FLUSH_EXTRA > 0) begin
                        fcnt_load = 1'b1;
                        state_d   = ST_FLUSH;
                    end
                end else if (mc_start) begin
                    // mc_cycles <= 1 finishes in the resolving stage untouched.
                    if (mc_cycles >= M_TWO) begin
                        lock     = stall_lock_mask;
                        clear    = stall_clr_mask;
                        pc_write = 1'b0;
                    end
                    if (mc_cycles >= M_THREE) begin
                        scnt_load = 1'b1;
                        state_d   = ST_MC_BUSY;
                    end
                end else if (load_use) begin
                    lock     = LU_LOCK;
                    clear    = LU_CLR;
                    pc_write = 1'b0;
                end
            end

            ST_MC_BUSY: begin
                // Upstream is frozen, so new requests cannot be real yet.
                lock     = stall_lock_mask;
                clear    = stall_clr_mask;
                pc_write = 1'b0;
                scnt_dec = 1'b1;
                if (scnt_done) begin
                    state_d = ST_RUN;
                end
            end

            ST_FLUSH: begin
                if (branch_taken) begin
                    clear      = br_clr_mask;
                    branch_acc = 1'b1;
                    fcnt_load  = 1'b1;
                end else begin
                    clear    = FLUSH_CLR;
                    fcnt_dec = 1'b1;
                    if (fcnt_done) begin
                        state_d = ST_RUN;
                    end
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (!reset_n) begin
            lock       = '0;
            clear      = '1;
            pc_write   = 1'b0;
            branch_acc = 1'b0;
        end
    end

    assign busy = reset_n && (state_q != ST_RUN);

`ifdef PIPE_PERF_CNT_EN
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] flush_count_q;

    // Saturating counters of stalled cycles and accepted branches.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            if (!pc_write && (stall_cycles_q != '1)) begin
                stall_cycles_q <= stall_cycles_q + PERF_W'(1);
            end
            if (branch_acc && (flush_count_q != '1)) begin
                flush_count_q <= flush_count_q + PERF_W'(1);
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (STAGES=4, BRANCH_STAGE=2).
// Two instances share the inputs: dut0 with FLUSH_EXTRA=0, dut2 with
// FLUSH_EXTRA=2. Outputs are checked as {lock, clear, pc_write, busy}.
module tb_pipeline_hazard_ctrl;

    logic       clock;
    logic       reset_n;
    logic       branch_taken;
    logic       load_use;
    logic       mc_start;
    logic [3:0] mc_cycles;

    logic [3:0] lock0, clear0, lock2, clear2;
    logic       pc_write0, busy0, pc_write2, busy2;
`ifdef PIPE_PERF_CNT_EN
    logic [15:0] stall_cycles0, flush_count0, stall_cycles2, flush_count2;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [9:0] RST   = {4'b0000, 4'b1111, 1'b0, 1'b0};
    localparam logic [9:0] IDLE  = {4'b1111, 4'b0000, 1'b1, 1'b0};
    localparam logic [9:0] BR    = {4'b1111, 4'b0011, 1'b1, 1'b0};
    localparam logic [9:0] BR_F  = {4'b1111, 4'b0011, 1'b1, 1'b1};
    localparam logic [9:0] FL    = {4'b1111, 4'b0001, 1'b1, 1'b1};
    localparam logic [9:0] LU    = {4'b1110, 4'b0010, 1'b0, 1'b0};
    localparam logic [9:0] MC0   = {4'b1100, 4'b0100, 1'b0, 1'b0};
    localparam logic [9:0] MCB   = {4'b1100, 4'b0100, 1'b0, 1'b1};

    wire [9:0] obs0 = {lock0, clear0, pc_write0, busy0};
    wire [9:0] obs2 = {lock2, clear2, pc_write2, busy2};

    pipeline_hazard_ctrl #(
        .STAGES(4), .BRANCH_STAGE(2), .FLUSH_EXTRA(0), .MC_CNT_W(4)
    ) dut0 (
        .clock(clock), .reset_n(reset_n), .branch_taken(branch_taken),
        .load_use(load_use), .mc_start(mc_start), .mc_cycles(mc_cycles),
        .lock(lock0), .clear(clear0), .pc_write(pc_write0), .busy(busy0)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles0), .flush_count(flush_count0)
`endif
    );

    pipeline_hazard_ctrl #(
        .STAGES(4), .BRANCH_STAGE(2), .FLUSH_EXTRA(2), .MC_CNT_W(4)
    ) dut2 (
        .clock(clock), .reset_n(reset_n), .branch_taken(branch_taken),
        .load_use(load_use), .mc_start(mc_start), .mc_cycles(mc_cycles),
        .lock(lock2), .clear(clear2), .pc_write(pc_write2), .busy(busy2)
`ifdef PIPE_PERF_CNT_EN
        , .stall_cycles(stall_cycles2), .flush_count(flush_count2)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 2 time units after the rising edge; checks follow #1 later.
    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    task automatic set_in(input logic b, input logic l, input logic m, input logic [3:0] mc);
        branch_taken = b;
        load_use     = l;
        mc_start     = m;
        mc_cycles    = mc;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            next_cycle();
            set_in(0, 0, 0, 4'd0);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        set_in(0, 0, 0, 4'd0);
        #2;
        checks++;
        if (obs0 !== RST) begin $display("FAIL reset_dut0 got %b exp %b", obs0, RST); errors++; end
        checks++;
        if (obs2 !== RST) begin $display("FAIL reset_dut2 got %b exp %b", obs2, RST); errors++; end
        next_cycle();
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL release_idle got %b exp %b", obs0, IDLE); errors++; end
        next_cycle();
        #1;
        checks++;
        if (obs2 !== IDLE) begin $display("FAIL release_idle2 got %b exp %b", obs2, IDLE); errors++; end
        $display("test_reset done");
    endtask

    task automatic test_branch();
        next_cycle();
        set_in(1, 0, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== BR) begin $display("FAIL branch_cycle got %b exp %b", obs0, BR); errors++; end
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL branch_after got %b exp %b", obs0, IDLE); errors++; end
        checks++;
        if (obs2 !== FL) begin $display("FAIL branch_flush2 got %b exp %b", obs2, FL); errors++; end
        idle_cycles(3);
        $display("test_branch done");
    endtask

    task automatic test_load_use();
        next_cycle();
        set_in(0, 1, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== LU) begin $display("FAIL load_use got %b exp %b", obs0, LU); errors++; end
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL load_use_after got %b exp %b", obs0, IDLE); errors++; end
        next_cycle();
        set_in(1, 1, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== BR) begin $display("FAIL lu_with_branch got %b exp %b", obs0, BR); errors++; end
        idle_cycles(4);
        $display("test_load_use done");
    endtask

    task automatic test_multicycle();
        logic [9:0] exp;
        // mc_cycles=4: three stall cycles; requests during MC_BUSY are ignored.
        next_cycle();
        set_in(0, 0, 1, 4'd4);
        #1;
        checks++;
        if (obs0 !== MC0) begin $display("FAIL mc4_c1 got %b exp %b", obs0, MC0); errors++; end
        next_cycle();
        set_in(1, 1, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== MCB) begin $display("FAIL mc4_c2 got %b exp %b", obs0, MCB); errors++; end
        next_cycle();
        set_in(0, 0, 1, 4'd9);
        #1;
        checks++;
        if (obs0 !== MCB) begin $display("FAIL mc4_c3 got %b exp %b", obs0, MCB); errors++; end
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL mc4_c4 got %b exp %b", obs0, IDLE); errors++; end
        // mc_cycles=1: no stall at all.
        next_cycle();
        set_in(0, 0, 1, 4'd1);
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL mc1 got %b exp %b", obs0, IDLE); errors++; end
        // mc_cycles=2: single stall cycle without entering MC_BUSY.
        next_cycle();
        set_in(0, 0, 1, 4'd2);
        #1;
        checks++;
        if (obs0 !== MC0) begin $display("FAIL mc2_c1 got %b exp %b", obs0, MC0); errors++; end
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL mc2_c2 got %b exp %b", obs0, IDLE); errors++; end
        // mc_cycles=15 (all ones): fourteen stall cycles, then idle.
        next_cycle();
        set_in(0, 0, 1, 4'd15);
        for (int i = 0; i < 15; i++) begin
            #1;
            exp = (i == 14) ? IDLE : ((i == 0) ? MC0 : MCB);
            checks++;
            if (obs0 !== exp) begin
                $display("FAIL mc15_c%0d got %b exp %b", i + 1, obs0, exp);
                errors++;
            end
            next_cycle();
            set_in(0, 0, 0, 4'd0);
        end
        idle_cycles(2);
        $display("test_multicycle done");
    endtask

    task automatic test_flush_extra();
        // Branch then load_use held high: load_use only honoured after the window.
        next_cycle();
        set_in(1, 1, 0, 4'd0);
        #1;
        checks++;
        if (obs2 !== BR) begin $display("FAIL fe_c0 got %b exp %b", obs2, BR); errors++; end
        next_cycle();
        set_in(0, 1, 0, 4'd0);
        #1;
        checks++;
        if (obs2 !== FL) begin $display("FAIL fe_c1 got %b exp %b", obs2, FL); errors++; end
        next_cycle();
        set_in(0, 1, 1, 4'd5);
        #1;
        checks++;
        if (obs2 !== FL) begin $display("FAIL fe_c2 got %b exp %b", obs2, FL); errors++; end
        next_cycle();
        set_in(0, 1, 0, 4'd0);
        #1;
        checks++;
        if (obs2 !== LU) begin $display("FAIL fe_c3 got %b exp %b", obs2, LU); errors++; end
        idle_cycles(3);
        // Branch inside the flush window reloads the window.
        next_cycle();
        set_in(1, 0, 0, 4'd0);
        next_cycle();
        set_in(1, 0, 0, 4'd0);
        #1;
        checks++;
        if (obs2 !== BR_F) begin $display("FAIL fe_rebranch got %b exp %b", obs2, BR_F); errors++; end
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        #1;
        checks++;
        if (obs2 !== FL) begin $display("FAIL fe_reload1 got %b exp %b", obs2, FL); errors++; end
        next_cycle();
        #1;
        checks++;
        if (obs2 !== FL) begin $display("FAIL fe_reload2 got %b exp %b", obs2, FL); errors++; end
        next_cycle();
        #1;
        checks++;
        if (obs2 !== IDLE) begin $display("FAIL fe_end got %b exp %b", obs2, IDLE); errors++; end
        idle_cycles(2);
        $display("test_flush_extra done");
    endtask

    task automatic test_reset_abort();
        // Reset in the third stall cycle of a 10-cycle op.
        next_cycle();
        set_in(0, 0, 1, 4'd10);
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        next_cycle();
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs0 !== RST) begin $display("FAIL abort_mc_rst got %b exp %b", obs0, RST); errors++; end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (stall_cycles0 !== 16'd0) begin $display("FAIL perf_stall_rst got %0d exp 0", stall_cycles0); errors++; end
`endif
        next_cycle();
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL abort_mc_rel got %b exp %b", obs0, IDLE); errors++; end
        next_cycle();
        #1;
        checks++;
        if (obs0 !== IDLE) begin $display("FAIL abort_mc_residual got %b exp %b", obs0, IDLE); errors++; end
`ifdef PIPE_PERF_CNT_EN
        checks++;
        if (stall_cycles0 !== 16'd0) begin $display("FAIL perf_stall_rel got %0d exp 0", stall_cycles0); errors++; end
`endif
        // Reset during the flush window of dut2.
        next_cycle();
        set_in(1, 0, 0, 4'd0);
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        reset_n = 1'b0;
        #1;
        checks++;
        if (obs2 !== RST) begin $display("FAIL abort_fl_rst got %b exp %b", obs2, RST); errors++; end
        next_cycle();
        reset_n = 1'b1;
        #1;
        checks++;
        if (obs2 !== IDLE) begin $display("FAIL abort_fl_rel got %b exp %b", obs2, IDLE); errors++; end
        $display("test_reset_abort done");
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        // One branch and a 3-cycle op from a clean reset.
        next_cycle();
        set_in(1, 0, 0, 4'd0);
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        idle_cycles(3);
        next_cycle();
        set_in(0, 0, 1, 4'd3);
        next_cycle();
        set_in(0, 0, 0, 4'd0);
        idle_cycles(2);
        #1;
        checks++;
        if (flush_count0 !== 16'd1) begin $display("FAIL perf_flush got %0d exp 1", flush_count0); errors++; end
        checks++;
        if (stall_cycles0 !== 16'd2) begin $display("FAIL perf_stall got %0d exp 2", stall_cycles0); errors++; end
        $display("test_perf done");
    endtask
`endif

    initial begin
        test_reset();
        test_branch();
        test_load_use();
        test_multicycle();
        test_flush_extra();
        test_reset_abort();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
